// File: rtl/readout_arbiter.sv
// Slot-based readout arbiter feeding the 27-bit output serializer: each slot carries
// a sync word, a round-robin granted requester word, an idle word, or nothing.
module readout_arbiter #(
    parameter int          NUM_REQ       = 4,
    parameter int          SLOT_PERIOD   = 8,
    parameter int          SYNC_INTERVAL = 16,
    parameter logic [26:0] SYNC_WORD     = 27'h5555555,
    parameter logic [26:0] IDLE_WORD     = 27'h7FFFFFF
) (
    input  logic                                             ClkBx,
    input  logic                                             ResetB,
    input  logic                                             Enable,
    input  logic                                             EnIdle,
    input  logic [NUM_REQ-1:0]                               Req,
    input  logic [NUM_REQ*27-1:0]                            DataIn,
    output logic [NUM_REQ-1:0]                               Ack,
    output logic                                             Read,
    output logic [26:0]                                      DataOut,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] GrantId,
    output logic [1:0]                                       WordType
);

    localparam int GW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW  = $clog2(SLOT_PERIOD);
    localparam int SCW = (SYNC_INTERVAL > 0) ? $clog2(SYNC_INTERVAL + 1) : 1;

    localparam logic [CW-1:0]  SLOT_LAST = CW'(SLOT_PERIOD - 1);
    localparam logic [SCW-1:0] SYNC_LIM  = SCW'(SYNC_INTERVAL);
    localparam logic [GW-1:0]  LAST_INIT = GW'(NUM_REQ - 1);
    localparam logic           SYNC_EN   = (SYNC_INTERVAL != 0);

    typedef enum logic [1:0] {
        WT_NONE = 2'd0,
        WT_DATA = 2'd1,
        WT_IDLE = 2'd2,
        WT_SYNC = 2'd3
    } word_type_e;

    logic [CW-1:0]      slot_cnt_r,     slot_cnt_nxt_s;
    logic [SCW-1:0]     sync_cnt_r,     sync_cnt_nxt_s;
    logic               sync_pending_r, sync_pending_nxt_s;
    logic [GW-1:0]      last_r,         last_nxt_s;
    logic [NUM_REQ-1:0] ack_r,          ack_nxt_s;
    logic               read_r,         read_nxt_s;
    logic [26:0]        data_out_r,     data_out_nxt_s;
    logic [GW-1:0]      grant_id_r,     grant_id_nxt_s;
    word_type_e         word_type_r,    word_type_nxt_s;

    logic [26:0]        req_word_s [NUM_REQ];
    logic [GW-1:0]      win_s;
    word_type_e         sel_s;
    logic [SCW-1:0]     sync_cnt_inc_s;
    logic [SCW-1:0]     bump_cnt_s;
    logic               bump_pending_s;
    int                 idx_s;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_word_s[g] = DataIn[27*g +: 27];
    end

    // Round-robin search: scan from farthest to nearest so the nearest requester after last_r wins.
    always_comb begin
        win_s = last_r;
        idx_s = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx_s = (int'(last_r) + k) % NUM_REQ;
            win_s = Req[GW'(idx_s)] ? GW'(idx_s) : win_s;
        end
    end

    // Slot content priority: pending sync, then data, then idle filler, else empty.
    always_comb begin
        if (sync_pending_r) begin
            sel_s = WT_SYNC;
        end else if (|Req) begin
            sel_s = WT_DATA;
        end else if (EnIdle) begin
            sel_s = WT_IDLE;
        end else begin
            sel_s = WT_NONE;
        end
    end

    // Sync counter advance for a data/idle word; reaching the interval schedules a sync.
    always_comb begin
        sync_cnt_inc_s = sync_cnt_r + SCW'(1);
        if (SYNC_EN && (sync_cnt_inc_s == SYNC_LIM)) begin
            bump_pending_s = 1'b1;
            bump_cnt_s     = {SCW{1'b0}};
        end else begin
            bump_pending_s = sync_pending_r;
            bump_cnt_s     = sync_cnt_inc_s;
        end
    end

    // Next-state for slot timing and all registered outputs.
    always_comb begin
        slot_cnt_nxt_s     = slot_cnt_r;
        sync_cnt_nxt_s     = sync_cnt_r;
        sync_pending_nxt_s = sync_pending_r;
        last_nxt_s         = last_r;
        ack_nxt_s          = {NUM_REQ{1'b0}};
        read_nxt_s         = 1'b0;
        data_out_nxt_s     = data_out_r;
        grant_id_nxt_s     = grant_id_r;
        word_type_nxt_s    = word_type_r;

        if (!Enable) begin
            slot_cnt_nxt_s     = {CW{1'b0}};
            sync_pending_nxt_s = SYNC_EN ? 1'b1 : sync_pending_r;
        end else begin
            slot_cnt_nxt_s = (slot_cnt_r == SLOT_LAST) ? {CW{1'b0}} : slot_cnt_r + CW'(1);
            if (slot_cnt_r == {CW{1'b0}}) begin
                case (sel_s)
                    WT_SYNC: begin
                        data_out_nxt_s     = SYNC_WORD;
                        word_type_nxt_s    = WT_SYNC;
                        read_nxt_s         = 1'b1;
                        sync_pending_nxt_s = 1'b0;
                        sync_cnt_nxt_s     = {SCW{1'b0}};
                    end
                    WT_DATA: begin
                        data_out_nxt_s     = req_word_s[win_s];
                        ack_nxt_s[win_s]   = 1'b1;
                        read_nxt_s         = 1'b1;
                        grant_id_nxt_s     = win_s;
                        last_nxt_s         = win_s;
                        word_type_nxt_s    = WT_DATA;
                        sync_cnt_nxt_s     = bump_cnt_s;
                        sync_pending_nxt_s = bump_pending_s;
                    end
                    WT_IDLE: begin
                        data_out_nxt_s     = IDLE_WORD;
                        word_type_nxt_s    = WT_IDLE;
                        read_nxt_s         = 1'b1;
                        sync_cnt_nxt_s     = bump_cnt_s;
                        sync_pending_nxt_s = bump_pending_s;
                    end
                    default: begin
                        word_type_nxt_s    = WT_NONE;
                    end
                endcase
            end else begin
                read_nxt_s = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge ClkBx or negedge ResetB) begin
        if (!ResetB) begin
            slot_cnt_r     <= {CW{1'b0}};
            sync_cnt_r     <= {SCW{1'b0}};
            sync_pending_r <= SYNC_EN;
            last_r         <= LAST_INIT;
            ack_r          <= {NUM_REQ{1'b0}};
            read_r         <= 1'b0;
            data_out_r     <= 27'h0;
            grant_id_r     <= {GW{1'b0}};
            word_type_r    <= WT_NONE;
        end else begin
            slot_cnt_r     <= slot_cnt_nxt_s;
            sync_cnt_r     <= sync_cnt_nxt_s;
            sync_pending_r <= sync_pending_nxt_s;
            last_r         <= last_nxt_s;
            ack_r          <= ack_nxt_s;
            read_r         <= read_nxt_s;
            data_out_r     <= data_out_nxt_s;
            grant_id_r     <= grant_id_nxt_s;
            word_type_r    <= word_type_nxt_s;
        end
    end

    assign Ack      = ack_r;
    assign Read     = read_r;
    assign DataOut  = data_out_r;
    assign GrantId  = grant_id_r;
    assign WordType = word_type_r;

endmodule
